bus_write_fifo: RTL and testbench
=================================

// Module: bus_write_fifo
// PURPOSE
//   Host-bus front end of the SN76489 core, sitting between the parallel pins (pD0..pD7, WEb)
//   and the register-write decoder (reception). Synchronises the asynchronous write strobe and
//   data, and detects each write. Generates the chip READY handshake and queues bytes in a
//   small FIFO, so back-to-back host writes are never lost while the decoder is busy.
// PARAMETERS
//   DEPTH        8   FIFO entries; power of 2, >=2
//   BUSY_CYCLES  32  clk cycles READY is held low after each accepted write (>=1)
//   FILTER_LEN   3   consecutive low samples needed on WEb (only with WEB_GLITCH_FILTER_EN)
// PORTS
//   clk        in   1  system clock; all logic on posedge
//   rst        in   1  synchronous, active-high reset
//   pd         in   8  host data pins {pD7..pD0}, asynchronous
//   web        in   1  host write strobe, active low, asynchronous
//   ready      out  1  1 = chip may accept a write (drives READY pin)
//   out_data   out  8  head-of-FIFO byte to the decoder (data_in)
//   out_valid  out  1  out_data valid (FIFO not empty)
//   out_ready  in   1  decoder accepts the byte this cycle
//   overflow   out  1  sticky: a write arrived while the FIFO was full
// BEHAVIOUR
//   Reset: ready=1, out_valid=0, out_data=0, overflow=0, FIFO empty, FSM=IDLE.
//     Synchroniser flops reset to web=1 / pd=0, so releasing rst never creates an edge.
//   Sync: 2-flop synchroniser on web and all 8 pd bits (equal delay; host holds data across WE).
//   Write detect: synced web 1->0 (prev=1, now=0) while FSM==IDLE.
//   Latency: web low first sampled at edge k -> byte pushed and ready=0 after edge k+2.
//     out_valid=1 after edge k+2 if the FIFO was empty (first-word fall-through).
//   FSM:
//     IDLE      : on write detect -> push synced pd, load busy counter = BUSY_CYCLES-1, -> BUSY
//     BUSY      : decrement counter; ready=0. At 0: web_s==1 -> IDLE, else -> WAIT_HIGH
//     WAIT_HIGH : ready per FIFO state; wait for web_s==1 -> IDLE. Long strobes yield one write.
//   ready = (FSM != BUSY) && !fifo_full. It is registered, with no combinational path from pins.
//   FIFO: wr/rd pointers of log2(DEPTH)+1 bits; full/empty from MSB compare; wrap modulo DEPTH.
//     Pop when out_valid && out_ready. out_data = mem[rd_ptr], stable while out_valid && !out_ready.
//     Push when full: byte dropped, overflow<=1 (cleared only by rst), FSM still goes to BUSY.
//     Push and pop in the same cycle when full: pop frees the slot and the push is accepted.
//     Push and pop in the same cycle when empty: no bypass. Byte visible next cycle, out_valid
//     stays 1 after.
//   Host violating READY (new falling edge while BUSY): ignored. Web must return high first.
//   rst mid-operation: FIFO contents discarded, counter cleared, outputs return to reset values
//     on the next edge.
// CONFIGURATION
//   WEB_GLITCH_FILTER_EN defined: a write is detected only after synced web has been low for
//     FILTER_LEN consecutive cycles (saturating counter, cleared when web_s=1). Pulses shorter
//     than that are ignored. Detect latency grows by FILTER_LEN-1 cycles; pd is sampled on the
//     detect cycle.
//   Undefined: single-sample edge detect as above. FILTER_LEN is unused.
// TESTING
//   1 Single write: pd=0x9F, web low 10 cycles -> out_valid@k+2 with out_data=0x9F,
//     ready low 32 cycles, overflow=0.
//   2 FIFO fill: out_ready=0, 9 writes 0x80..0x88 each after ready high -> ready stays 0 once
//     8 are queued. 9th dropped, overflow=1; drain yields 0x80..0x87 in order.
//   3 Full+pop: FIFO full, out_ready=1 on the same cycle as a write of 0xA5 -> write accepted,
//     count stays 8, overflow=0.
//   4 Long strobe: web low 100 cycles -> exactly one push, FSM in WAIT_HIGH until web high.
//   5 Reset mid-busy: rst at cycle 10 of BUSY with 3 bytes queued -> next edge: ready=1,
//     out_valid=0, overflow=0, no push when rst falls with web=1.
//   6 Glitch (macro defined, FILTER_LEN=3): 2-cycle web low -> no push. 3-cycle low -> one push.

Source files
------------

// File: rtl/bus_write_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bus_write_fifo                                                             |
// | Host-bus write front end: pin synchroniser, write detect, READY handshake  |
// | and a small first-word-fall-through byte FIFO toward the register decoder. |
// | Optional feature macro: WEB_GLITCH_FILTER_EN (minimum-width WEb filter).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bus_write_fifo #(
  parameter int DEPTH       = 8,
  parameter int BUSY_CYCLES = 32,
  parameter int FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pd,
  input  logic       web,
  output logic       ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = $clog2(BUSY_CYCLES) + 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BUSY      = 2'd1,
    ST_WAIT_HIGH = 2'd2
  } state_t;

  state_t            r_state;
  logic [c_cw-1:0]   r_cnt;
  logic              r_ready;
  logic              r_overflow;
  logic              r_web_s1;
  logic              r_web_s2;
  logic [7:0]        r_pd_s1;
  logic [7:0]        r_pd_s2;
  logic [7:0]        r_mem [DEPTH];
  logic [c_aw:0]     r_wr_ptr;
  logic [c_aw:0]     r_rd_ptr;

  logic              w_detect;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_busy_next;
  logic              w_full_next;
  logic [c_aw:0]     w_wr_next;
  logic [c_aw:0]     w_rd_next;

  // Web resets high so releasing rst can never look like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_web_s1 <= 1'b1;
      r_web_s2 <= 1'b1;
      r_pd_s1  <= 8'h00;
      r_pd_s2  <= 8'h00;
    end else begin
      r_web_s1 <= web;
      r_web_s2 <= r_web_s1;
      r_pd_s1  <= pd;
      r_pd_s2  <= r_pd_s1;
    end
  end

`ifdef WEB_GLITCH_FILTER_EN
  localparam int c_fw = $clog2(FILTER_LEN + 1);
  logic [c_fw-1:0] r_low_cnt;

  always_ff @(posedge clk) begin
    if (rst || r_web_s2) begin
      r_low_cnt <= '0;
    end else if (r_low_cnt != c_fw'(FILTER_LEN)) begin
      r_low_cnt <= r_low_cnt + 1'b1;
    end
  end

  // Fires once per strobe, on the cycle the low run reaches FILTER_LEN.
  assign w_detect = (r_state == ST_IDLE) && !r_web_s2 &&
                    (r_low_cnt == c_fw'(FILTER_LEN - 1));
`else
  logic r_web_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_web_prev <= 1'b1;
    end else begin
      r_web_prev <= r_web_s2;
    end
  end

  assign w_detect = (r_state == ST_IDLE) && r_web_prev && !r_web_s2 &&
                    (FILTER_LEN > 0);
`endif

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_pop   = !w_empty && out_ready;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign w_push  = w_detect && (!w_full || w_pop);

  assign w_wr_next   = r_wr_ptr + {{c_aw{1'b0}}, w_push};
  assign w_rd_next   = r_rd_ptr + {{c_aw{1'b0}}, w_pop};
  assign w_full_next = (w_wr_next[c_aw] != w_rd_next[c_aw]) &&
                       (w_wr_next[c_aw-1:0] == w_rd_next[c_aw-1:0]);
  assign w_busy_next = ((r_state == ST_IDLE) && w_detect) ||
                       ((r_state == ST_BUSY) && (r_cnt != '0));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_aw-1:0]] <= r_pd_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_ready    <= 1'b1;
      r_overflow <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_detect) begin
            r_cnt   <= c_cw'(BUSY_CYCLES - 1);
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_cnt == '0) begin
            r_state <= r_web_s2 ? ST_IDLE : ST_WAIT_HIGH;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_WAIT_HIGH: begin
          if (r_web_s2) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      r_ready  <= !w_busy_next && !w_full_next;
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      if (w_detect && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign ready     = r_ready;
  assign overflow  = r_overflow;
  assign out_valid = !w_empty;
  assign out_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr[c_aw-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_bus_write_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bus_write_fifo                                                          |
// | Randomised host writes against a queue model with a decoupled monitor.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_bus_write_fifo;

  localparam int DEPTH       = 8;
  localparam int BUSY_CYCLES = 32;
  localparam int FILTER_LEN  = 3;
`ifdef WEB_GLITCH_FILTER_EN
  localparam int c_lat = 3 + FILTER_LEN - 1;
`else
  localparam int c_lat = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pd  = 8'h00;
  logic       web = 1'b1;
  logic       out_ready = 1'b0;
  logic       ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       overflow;

  bus_write_fifo #(
    .DEPTH      (DEPTH),
    .BUSY_CYCLES(BUSY_CYCLES),
    .FILTER_LEN (FILTER_LEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pd       (pd),
    .web      (web),
    .ready    (ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  bit         exp_ovf = 1'b0;
  int         rdy_mode = 0;
  int         run_len = 0;
  int         last_low = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the model queue defines what the FIFO must present.
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", out_valid, int'(exp_q.size() != 0));
      check("overflow", overflow, exp_ovf);
      if (out_valid && out_ready && exp_q.size() != 0) begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      2: out_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  always @(posedge clk) begin
    #1;
    if (rst) run_len = 0;
    else if (!ready) run_len++;
    else if (run_len != 0) begin
      last_low = run_len;
      run_len  = 0;
    end
  end

  task automatic model_push(input logic [7:0] d);
    check("push_ready_low", ready, 0);
    check("push_valid", out_valid, 1);
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else exp_ovf = 1'b1;
  endtask

  task automatic host_write(input logic [7:0] d, input int low_len, input bit need_ready,
                            input bit exp_push, input bit pop_at_push);
    int n = 0;
    if (need_ready) begin
      while (!ready && n < 2000) begin
        @(posedge clk); #1;
        n++;
      end
      check("ready_wait_timeout", int'(n >= 2000), 0);
    end
    @(posedge clk); #1;
    web = 1'b0;
    pd  = d;
    if (exp_push) begin
      fork
        begin
          automatic logic [7:0] dd = d;
          automatic bit pp = pop_at_push;
          repeat (c_lat - 1) @(posedge clk);
          #1;
          if (pp) out_ready = 1'b1;
          @(posedge clk); #1;
          if (pp) out_ready = 1'b0;
          model_push(dd);
        end
      join_none
    end
    repeat (low_len) @(posedge clk);
    #1;
    web = 1'b1;
    repeat (c_lat + 3) @(posedge clk);
  endtask

  task automatic do_reset(input bit check_vals);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    if (check_vals) begin
      check("rst_ready", ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_overflow", overflow, 0);
    end
    exp_q.delete();
    exp_ovf = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic drain();
    int n = 0;
    rdy_mode = 1;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", int'(n >= 500), 0);
    repeat (3) @(posedge clk);
    rdy_mode = 0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    do_reset(1'b1);

    // Single write, READY low for the busy window
    host_write(8'h9F, 10, 1'b1, 1'b1, 1'b0);
    n = 0;
    while (!ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    check("t1_busy_len", last_low, BUSY_CYCLES);
    check("t1_data", out_data, 8'h9F);
    drain();

    // Fill past depth: ninth byte dropped
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) host_write(8'h80 + 8'(i), 3, 1'b1, 1'b1, 1'b0);
    repeat (BUSY_CYCLES + 8) @(posedge clk);
    #1 check("t2_full_ready", ready, 0);
    host_write(8'h88, 3, 1'b0, 1'b1, 1'b0);
    repeat (BUSY_CYCLES + 8) @(posedge clk);
    #1 check("t2_overflow", overflow, 1);
    drain();
    #1 check("t2_ready_after_drain", ready, 1);

    // Full FIFO, pop coincides with push
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) host_write(8'h10 + 8'(i), 3, 1'b1, 1'b1, 1'b0);
    repeat (BUSY_CYCLES + 8) @(posedge clk);
    rdy_mode = 3;
    out_ready = 1'b0;
    host_write(8'hA5, 3, 1'b0, 1'b1, 1'b1);
    repeat (BUSY_CYCLES + 8) @(posedge clk);
    #1 check("t3_still_full", ready, 0);
    rdy_mode = 0;
    drain();

    // Long strobe yields one write; READY returns while web still low
    do_reset(1'b0);
    fork
      begin
        repeat (70) @(posedge clk);
        #1 check("t4_wait_high_ready", ready, 1);
      end
    join_none
    host_write(8'h3C, 100, 1'b1, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    drain();

    // Reset during BUSY with three bytes queued
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) host_write(8'h40 + 8'(i), 3, 1'b1, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    do_reset(1'b1);
    repeat (10) @(posedge clk);

    // Randomised traffic with random decoder back-pressure
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      host_write(8'($urandom), $urandom_range(12, FILTER_LEN), 1'b1, 1'b1, 1'b0);
    end
    drain();

`ifdef WEB_GLITCH_FILTER_EN
    do_reset(1'b0);
    host_write(8'h11, FILTER_LEN - 1, 1'b1, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1 check("t6_glitch_ready", ready, 1);
    host_write(8'h22, FILTER_LEN, 1'b1, 1'b1, 1'b0);
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
